// File: rtl/program_memory_loader.sv
// Instruction memory for the 8-bit CPU. It has a byte-stream loader and holds the CPU in reset
// while the RAM is being cleared or loaded, so the CPU only ever fetches a settled image.
module program_memory_loader #(
    parameter int          ADDR_W  = 8,
    parameter logic [7:0]  HALT_OP = 8'hC3,
    parameter logic [7:0]  NOP_OP  = 8'hC0
) (
    input  logic              oscillator,
    input  logic              reset,
    input  logic [ADDR_W-1:0] instruction_address,
    output logic [7:0]        instruction,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    input  logic              load_end,
    output logic [ADDR_W-1:0] load_count,
    output logic              load_overflow,
    output logic              cpu_reset
);

    typedef enum logic [1:0] {FILL, LOAD, RUN} state_t;

    state_t            state, next_state;
    logic [ADDR_W:0]   wp, wp_next;
    logic [ADDR_W-1:0] count_next;
    logic              overflow_next;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              handshake;
    logic [7:0]        mem [2**ADDR_W];

    assign load_ready = (state == LOAD) && !wp[ADDR_W];
    assign handshake  = load_valid && load_ready;

    always_comb begin
        next_state    = state;
        wp_next       = wp;
        count_next    = load_count;
        overflow_next = load_overflow;
        wr_en         = 1'b0;
        wr_data       = HALT_OP;
        if (load_start) begin
            next_state    = LOAD;
            wp_next       = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end else begin
            case (state)
                FILL: begin
                    wr_en   = 1'b1;
                    wp_next = wp + 1'b1;
                    if (wp[ADDR_W-1:0] == '1)
                        next_state = RUN;
                end
                LOAD: begin
                    if (handshake) begin
                        wr_en   = 1'b1;
                        wr_data = load_data;
                        wp_next = wp + 1'b1;
                        if (load_count != '1)
                            count_next = load_count + 1'b1;
                    end else if (load_valid && wp[ADDR_W]) begin
                        overflow_next = 1'b1;
                    end
                    // Decide on the post-write pointer so that a final byte arriving with
                    // load_end that fills the memory does not leave FILL to wrap over address 0.
                    if (load_end)
                        next_state = wp_next[ADDR_W] ? RUN : FILL;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge oscillator or negedge reset) begin
        if (!reset) begin
            state         <= FILL;
            wp            <= '0;
            load_count    <= '0;
            load_overflow <= 1'b0;
            cpu_reset     <= 1'b1;
            instruction   <= NOP_OP;
        end else begin
            state         <= next_state;
            wp            <= wp_next;
            load_count    <= count_next;
            load_overflow <= overflow_next;
            cpu_reset     <= (next_state != RUN);
            instruction   <= (state == RUN) ? mem[instruction_address] : NOP_OP;
        end
    end

    always_ff @(posedge oscillator) begin
        if (wr_en)
            mem[wp[ADDR_W-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: reset/fill timing, loads, overflow, restarts,
// with a plain array model of the expected memory image.
module tb_program_memory_loader;

    logic       oscillator = 1'b0;
    logic       reset;
    logic [7:0] instruction_address;
    logic [7:0] instruction;
    logic       load_start, load_valid, load_end;
    logic [7:0] load_data;
    logic       load_ready;
    logic [7:0] load_count;
    logic       load_overflow;
    logic       cpu_reset;

    always #5 oscillator = ~oscillator;

    program_memory_loader dut (
        .oscillator(oscillator), .reset(reset),
        .instruction_address(instruction_address), .instruction(instruction),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_end(load_end), .load_count(load_count),
        .load_overflow(load_overflow), .cpu_reset(cpu_reset)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] model_mem [256];
    int         model_wp;
    int         cnt;
    rd_vec_t    rd_tab [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge oscillator);
        @(negedge oscillator);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'hC3;
    endtask

    task automatic model_pad();
        for (int i = model_wp; i < 256; i++) model_mem[i] = 8'hC3;
    endtask

    function automatic int model_count();
        return (model_wp > 255) ? 255 : model_wp;
    endfunction

    // Counts cycles until the CPU is released, checking the NOP byte throughout.
    task automatic wait_run(output int cycles);
        int bad;
        bad = 0;
        cycles = 0;
        while (cpu_reset === 1'b1 && cycles < 600) begin
            if (instruction !== 8'hC0) bad++;
            tick();
            cycles++;
        end
        check("fill_nop", bad, 0);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        model_wp = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps, input bit with_end);
        load_valid = 1'b0;
        repeat (gaps) tick();
        load_valid = 1'b1;
        load_data  = b;
        load_end   = with_end;
        check("ready_before_byte", load_ready, (model_wp < 256));
        if (model_wp < 256) begin
            model_mem[model_wp] = b;
            model_wp++;
        end
        tick();
        load_valid = 1'b0;
        load_end   = 1'b0;
    endtask

    task automatic pulse_end();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        model_pad();
    endtask

    task automatic read_chk(input logic [7:0] addr, input string name);
        instruction_address = addr;
        tick();
        check(name, instruction, model_mem[addr]);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_instr"}, instruction, 8'hC0);
        check({tag, "_ready"}, load_ready, 1'b0);
        check({tag, "_count"}, load_count, 8'd0);
        check({tag, "_ovf"}, load_overflow, 1'b0);
        check({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    endtask

    initial begin
        int n;
        rd_tab[0] = '{8'd0,   8'h01};
        rd_tab[1] = '{8'd1,   8'h46};
        rd_tab[2] = '{8'd2,   8'hC3};
        rd_tab[3] = '{8'd3,   8'hC3};
        rd_tab[4] = '{8'd255, 8'hC3};

        reset = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0;
        load_data = 8'h00; instruction_address = 8'h00;
        model_wp = 0;

        // 1: reset state, full clear, reads return HALT.
        repeat (3) tick();
        check_reset_values("rst");
        reset = 1'b1;
        model_clear();
        wait_run(cnt);
        check("fill_cycles_reset", cnt, 256);
        for (int i = 0; i < 4; i++) read_chk(8'($urandom_range(0, 255)), "read_after_clear");

        // 2: short load with gaps, padded by FILL.
        pulse_start();
        check("load_cpu_reset", cpu_reset, 1'b1);
        check("load_count_start", load_count, 8'd0);
        send_byte(8'h01, 2, 1'b0);
        send_byte(8'h46, 0, 1'b0);
        send_byte(8'hC3, 3, 1'b0);
        pulse_end();
        check("count_3", load_count, 8'd3);
        wait_run(cnt);
        check("pad_cycles_3", cnt, 253);
        for (int i = 0; i < 5; i++) begin
            instruction_address = rd_tab[i].addr;
            tick();
            check("table_read", instruction, rd_tab[i].exp);
        end

        // 3: full load plus an overflowing byte.
        pulse_start();
        for (int i = 0; i < 256; i++) send_byte(8'($urandom), 0, 1'b0);
        check("ready_when_full", load_ready, 1'b0);
        check("count_full", load_count, 8'd255);
        send_byte(8'h5A, 0, 1'b0);
        check("overflow_set", load_overflow, 1'b1);
        check("count_full_after_ovf", load_count, 8'd255);
        pulse_end();
        check("full_straight_to_run", cpu_reset, 1'b0);
        check("overflow_sticky_in_run", load_overflow, 1'b1);
        read_chk(8'd0, "full_mem0");
        read_chk(8'd255, "full_mem255");
        for (int i = 0; i < 4; i++) read_chk(8'($urandom_range(0, 255)), "full_rand");

        // 4: random loads whose last byte arrives with load_end.
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(3, 40);
            pulse_start();
            check("ovf_cleared_by_start", load_overflow, 1'b0);
            for (int i = 0; i < n; i++)
                send_byte(8'($urandom), $urandom_range(0, 2), (i == n - 1));
            model_pad();
            check("end_same_cycle_count", load_count, model_count());
            check("end_same_cycle_fill", cpu_reset, 1'b1);
            wait_run(cnt);
            check("pad_cycles_rand", cnt, 256 - n);
            for (int a = 0; a <= n; a++) read_chk(8'(a), "rand_load_read");
            read_chk(8'($urandom_range(41, 255)), "rand_pad_read");
        end

        // 5: asynchronous reset in the middle of a load.
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 191)), 0, 1'b0);
        check("count_10", load_count, 8'd10);
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge oscillator);
        reset = 1'b1;
        model_clear();
        wait_run(cnt);
        check("fill_cycles_after_async", cnt, 256);
        read_chk(8'd0, "addr0_after_async");

        // 6: load_start interrupts FILL, then restarts a load.
        reset = 1'b0;
        @(negedge oscillator);
        reset = 1'b1;
        repeat (100) tick();
        check("fill_in_progress", cpu_reset, 1'b1);
        pulse_start();
        check("load_from_fill_ready", load_ready, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0, 1'b0);
        check("count_5", load_count, 8'd5);
        pulse_start();
        check("restart_count_0", load_count, 8'd0);
        send_byte(8'h11, 1, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        pulse_end();
        wait_run(cnt);
        check("pad_cycles_restart", cnt, 254);
        for (int a = 0; a < 6; a++) read_chk(8'(a), "restart_read");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
